// File: rtl/bullet_pkg.sv
// Shared types for the bullet pool: entry record, colour codes and sweep FSM states.
// Entry field widths are fixed here, so COORD_W/COLOR_W on bullet_pool must keep these values.
package bullet_pkg;

    localparam int BP_COORD_W = 8;
    localparam int BP_COLOR_W = 3;

    localparam logic [BP_COLOR_W-1:0] COL_WHITE = 3'b000;
    localparam logic [BP_COLOR_W-1:0] COL_GREEN = 3'b001;
    localparam logic [BP_COLOR_W-1:0] COL_BLUE  = 3'b010;

    typedef struct packed {
        logic                  active;
        logic [BP_COLOR_W-1:0] color;
        logic [BP_COORD_W-1:0] w;
        logic [BP_COORD_W-1:0] h;
        logic [BP_COORD_W-1:0] x;
        logic [BP_COORD_W-1:0] y;
    } bullet_t;

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } state_e;

endpackage

// File: rtl/bullet_alloc.sv
// Lowest-index free slot finder over the pool's active vector (purely combinational).
module bullet_alloc #(
    parameter int NUM = 8,
    parameter int IW  = $clog2(NUM)
) (
    input  logic [NUM-1:0] active_i,
    output logic [IW-1:0]  free_idx_o,
    output logic           any_free_o
);

    // Scan downwards so the last hit, the lowest free index, wins.
    always_comb begin
        free_idx_o = '0;
        any_free_o = 1'b0;
        for (int i = NUM - 1; i >= 0; i--) begin
            if (!active_i[i]) begin
                free_idx_o = IW'(i);
                any_free_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bullet_pool.sv
// Bullet store and per-frame motion engine with spawn handshake and two read ports.
// Define BULLET_WRAP_EN to wrap out-of-range axes instead of deactivating the bullet.
module bullet_pool
    import bullet_pkg::*;
#(
    parameter int NUM_BULLETS = 8,
    parameter int COORD_W     = BP_COORD_W,
    parameter int COLOR_W     = BP_COLOR_W,
    parameter int VEL_W       = 4,
    parameter int X_MAX       = 200,
    parameter int Y_MAX       = 200,
    localparam int IDX_W      = $clog2(NUM_BULLETS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 frame_tick,
    input  logic                 spawn_valid,
    output logic                 spawn_ready,
    input  logic [COORD_W-1:0]   spawn_x,
    input  logic [COORD_W-1:0]   spawn_y,
    input  logic [COORD_W-1:0]   spawn_w,
    input  logic [COORD_W-1:0]   spawn_h,
    input  logic [COLOR_W-1:0]   spawn_color,
    input  logic [VEL_W-1:0]     spawn_vx,
    input  logic [VEL_W-1:0]     spawn_vy,
    output logic [IDX_W-1:0]     spawn_idx,
    input  logic [IDX_W-1:0]     rd_idx_a,
    input  logic [IDX_W-1:0]     rd_idx_b,
    output logic [2*COORD_W-1:0] pos_a,
    output logic [2*COORD_W-1:0] size_a,
    output logic [COLOR_W-1:0]   color_a,
    output logic                 render_a,
    output logic [2*COORD_W-1:0] pos_b,
    output logic [2*COORD_W-1:0] size_b,
    output logic [COLOR_W-1:0]   color_b,
    output logic                 render_b,
    output logic [IDX_W:0]       active_count,
    output logic                 busy,
    output logic                 tick_overrun
);

    localparam int SW = COORD_W + 2;
    localparam logic signed [SW-1:0] XLIM = SW'(X_MAX);
    localparam logic signed [SW-1:0] YLIM = SW'(Y_MAX);
    localparam logic [IDX_W-1:0]     LAST = IDX_W'(NUM_BULLETS - 1);

    bullet_t          ent_q [NUM_BULLETS];
    bullet_t          ent_d [NUM_BULLETS];
    logic [VEL_W-1:0] vx_q  [NUM_BULLETS];
    logic [VEL_W-1:0] vx_d  [NUM_BULLETS];
    logic [VEL_W-1:0] vy_q  [NUM_BULLETS];
    logic [VEL_W-1:0] vy_d  [NUM_BULLETS];

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   spawn_idx_q, spawn_idx_d;
    logic [IDX_W:0]     count_q, count_d;
    logic               overrun_q, overrun_d;

    logic [NUM_BULLETS-1:0] active_vec;
    logic [IDX_W-1:0]       free_idx;
    logic                   any_free;
    logic                   spawn_fire;
    logic                   tick_go;

    logic signed [SW-1:0]   nx, ny;
    logic                   out_of_range;

`ifdef BULLET_WRAP_EN
    function automatic logic [COORD_W-1:0] wrapAxis(input logic signed [SW-1:0] v,
                                                    input logic signed [SW-1:0] lim);
        logic signed [SW-1:0] r;
        r = v;
        if (v > lim)
            r = v - (lim + $signed(SW'(1)));
        else if (v < 0)
            r = v + (lim + $signed(SW'(1)));
        return r[COORD_W-1:0];
    endfunction
`endif

    always_comb begin
        for (int i = 0; i < NUM_BULLETS; i++)
            active_vec[i] = ent_q[i].active;
    end

    bullet_alloc #(
        .NUM (NUM_BULLETS),
        .IW  (IDX_W)
    ) u_alloc (
        .active_i   (active_vec),
        .free_idx_o (free_idx),
        .any_free_o (any_free)
    );

    assign spawn_ready = (state_q == ST_IDLE) && any_free;
    assign spawn_fire  = spawn_valid && spawn_ready;
    assign tick_go     = frame_tick && run;

    // Candidate position of the entry under the sweep pointer, widened so underflow stays visible.
    always_comb begin
        nx = $signed({2'b00, ent_q[ptr_q].x})
           + $signed({{(SW-VEL_W){vx_q[ptr_q][VEL_W-1]}}, vx_q[ptr_q]});
        ny = $signed({2'b00, ent_q[ptr_q].y})
           + $signed({{(SW-VEL_W){vy_q[ptr_q][VEL_W-1]}}, vy_q[ptr_q]});
        out_of_range = (nx < 0) || (nx > XLIM) || (ny < 0) || (ny > YLIM);
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        spawn_idx_d = spawn_idx_q;
        count_d     = count_q;
        overrun_d   = overrun_q;
        ent_d       = ent_q;
        vx_d        = vx_q;
        vy_d        = vy_q;

        case (state_q)
            ST_IDLE: begin
                if (spawn_fire) begin
                    ent_d[free_idx].active = 1'b1;
                    ent_d[free_idx].color  = spawn_color;
                    ent_d[free_idx].w      = spawn_w;
                    ent_d[free_idx].h      = spawn_h;
                    ent_d[free_idx].x      = spawn_x;
                    ent_d[free_idx].y      = spawn_y;
                    vx_d[free_idx]         = spawn_vx;
                    vy_d[free_idx]         = spawn_vy;
                    spawn_idx_d            = free_idx;
                    count_d                = count_q + 1'b1;
                end
                if (tick_go) begin
                    state_d = ST_SWEEP;
                    ptr_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (tick_go)
                    overrun_d = 1'b1;
                if (ent_q[ptr_q].active) begin
`ifdef BULLET_WRAP_EN
                    ent_d[ptr_q].x = wrapAxis(nx, XLIM);
                    ent_d[ptr_q].y = wrapAxis(ny, YLIM);
`else
                    if (out_of_range) begin
                        ent_d[ptr_q].active = 1'b0;
                        count_d             = count_q - 1'b1;
                    end else begin
                        ent_d[ptr_q].x = nx[COORD_W-1:0];
                        ent_d[ptr_q].y = ny[COORD_W-1:0];
                    end
`endif
                end
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            spawn_idx_q <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                ent_q[i] <= '0;
                vx_q[i]  <= '0;
                vy_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            spawn_idx_q <= spawn_idx_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            ent_q       <= ent_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
        end
    end

    assign spawn_idx    = spawn_idx_q;
    assign active_count = count_q;
    assign busy         = (state_q == ST_SWEEP);
    assign tick_overrun = overrun_q;

    assign pos_a    = {ent_q[rd_idx_a].x, ent_q[rd_idx_a].y};
    assign size_a   = {ent_q[rd_idx_a].w, ent_q[rd_idx_a].h};
    assign color_a  = ent_q[rd_idx_a].color;
    assign render_a = ent_q[rd_idx_a].active;

    assign pos_b    = {ent_q[rd_idx_b].x, ent_q[rd_idx_b].y};
    assign size_b   = {ent_q[rd_idx_b].w, ent_q[rd_idx_b].h};
    assign color_b  = ent_q[rd_idx_b].color;
    assign render_b = ent_q[rd_idx_b].active;

endmodule

// File: tb/tb_bullet_pool.sv
// Scoreboard bench for bullet_pool: stimulus queues expected spawn indices and post-sweep
// snapshots, a monitor compares them when a transfer happens or a sweep ends.
module tb_bullet_pool;
    import bullet_pkg::*;

    // Velocity is widened to 5 bits so the +10 pixels-per-tick scenario is representable.
    localparam int N  = 8;
    localparam int VW = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        frame_tick = 1'b0;
    logic        spawn_valid = 1'b0;
    logic        spawn_ready;
    logic [7:0]  spawn_x = '0, spawn_y = '0, spawn_w = '0, spawn_h = '0;
    logic [2:0]  spawn_color = '0;
    logic [VW-1:0] spawn_vx = '0, spawn_vy = '0;
    logic [2:0]  spawn_idx;
    logic [2:0]  rd_idx_a = '0, rd_idx_b = '0;
    logic [15:0] pos_a, size_a, pos_b, size_b;
    logic [2:0]  color_a, color_b;
    logic        render_a, render_b;
    logic [3:0]  active_count;
    logic        busy;
    logic        tick_overrun;

    always #5 clk = ~clk;

    bullet_pool #(
        .NUM_BULLETS (N),
        .VEL_W       (VW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .frame_tick   (frame_tick),
        .spawn_valid  (spawn_valid),
        .spawn_ready  (spawn_ready),
        .spawn_x      (spawn_x),
        .spawn_y      (spawn_y),
        .spawn_w      (spawn_w),
        .spawn_h      (spawn_h),
        .spawn_color  (spawn_color),
        .spawn_vx     (spawn_vx),
        .spawn_vy     (spawn_vy),
        .spawn_idx    (spawn_idx),
        .rd_idx_a     (rd_idx_a),
        .rd_idx_b     (rd_idx_b),
        .pos_a        (pos_a),
        .size_a       (size_a),
        .color_a      (color_a),
        .render_a     (render_a),
        .pos_b        (pos_b),
        .size_b       (size_b),
        .color_b      (color_b),
        .render_b     (render_b),
        .active_count (active_count),
        .busy         (busy),
        .tick_overrun (tick_overrun)
    );

    typedef struct {
        logic [15:0] pos;
        logic        render;
        logic [3:0]  count;
    } sweepExp_t;

    int        compared = 0;
    int        mismatched = 0;
    int        spawnQ[$];
    sweepExp_t sweepQ[$];

    function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: a spawn transfer or the end of a sweep pops one expectation.
    always begin : monitor
        logic      fire, wasBusy;
        int        expIdx;
        sweepExp_t e;
        @(posedge clk);
        fire    = spawn_valid && spawn_ready;
        wasBusy = busy;
        #1;
        if (rst_n) begin
            if (fire) begin
                if (spawnQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL spawnUnexpected: got transfer to %0d expected none", spawn_idx);
                end else begin
                    expIdx = spawnQ.pop_front();
                    checkOutput("spawnIdx", 32'(spawn_idx), 32'(expIdx));
                end
            end
            if (wasBusy && !busy) begin
                if (sweepQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL sweepUnexpected: got sweep end expected none");
                end else begin
                    e = sweepQ.pop_front();
                    checkOutput("sweepPosA", 32'(pos_a), 32'(e.pos));
                    checkOutput("sweepRenderA", 32'(render_a), 32'(e.render));
                    checkOutput("sweepCount", 32'(active_count), 32'(e.count));
                end
            end
        end
    end

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        spawn_valid = 1'b0;
        frame_tick = 1'b0;
        run = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic [7:0] w,
                                 input logic [7:0] h, input logic [2:0] c,
                                 input logic [VW-1:0] vx, input logic [VW-1:0] vy, input int expIdx);
        int n;
        @(negedge clk);
        spawn_x = x; spawn_y = y; spawn_w = w; spawn_h = h;
        spawn_color = c; spawn_vx = vx; spawn_vy = vy;
        spawn_valid = 1'b1;
        n = 0;
        while (!spawn_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("spawnReadyWait", 32'(spawn_ready), 32'd1);
        spawnQ.push_back(expIdx);
        @(negedge clk);
        spawn_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("sweepFinished", 32'(busy), 32'd0);
    endtask

    task automatic applyTick(input logic [15:0] pos, input logic render, input logic [3:0] count);
        sweepExp_t e;
        e.pos = pos; e.render = render; e.count = count;
        @(negedge clk);
        sweepQ.push_back(e);
        run = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        waitIdle();
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int cnt;
        sweepExp_t e;

        // Reset state and first spawn.
        applyReset();
        @(negedge clk);
        checkOutput("rstSpawnIdx", 32'(spawn_idx), 32'd0);
        checkOutput("rstCount", 32'(active_count), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstOverrun", 32'(tick_overrun), 32'd0);
        checkOutput("rstPosA", 32'(pos_a), 32'd0);
        checkOutput("rstRenderA", 32'(render_a), 32'd0);
        checkOutput("rstReady", 32'(spawn_ready), 32'd1);

        rd_idx_a = 3'd0;
        applyStimulus(8'd64, 8'd19, 8'd4, 8'd6, COL_GREEN, 5'd0, 5'd10, 0);
        checkOutput("spawnRenderA", 32'(render_a), 32'd1);
        checkOutput("spawnPosA", 32'(pos_a), 32'h4013);
        checkOutput("spawnCount", 32'(active_count), 32'd1);
        checkOutput("spawnColorA", 32'(color_a), 32'(COL_GREEN));

        // Nineteen ticks: y = 19 + 10k, leaving the field on tick 19.
        for (int k = 1; k <= 18; k++)
            applyTick({8'd64, 8'(19 + 10 * k)}, 1'b1, 4'd1);
`ifdef BULLET_WRAP_EN
        applyTick({8'd64, 8'd8}, 1'b1, 4'd1);
`else
        applyTick({8'd64, 8'd199}, 1'b0, 4'd0);
`endif

        // Fill every slot, then free slot 3 while a spawn is held pending.
        applyReset();
        for (int i = 0; i < N; i++) begin
            if (i == 3)
                applyStimulus(8'd195, 8'd100, 8'd2, 8'd2, COL_WHITE, 5'd7, 5'd0, i);
            else
                applyStimulus(8'(8 * i), 8'd100, 8'd2, 8'd2, COL_WHITE, 5'd0, 5'd0, i);
        end
        checkOutput("fullReady", 32'(spawn_ready), 32'd0);
        checkOutput("fullCount", 32'(active_count), 32'd8);
        rd_idx_a = 3'd3;
`ifdef BULLET_WRAP_EN
        applyTick({8'd1, 8'd100}, 1'b1, 4'd8);
        checkOutput("wrapStillFull", 32'(spawn_ready), 32'd0);
`else
        spawnQ.push_back(3);
        spawn_x = 8'd10; spawn_y = 8'd10; spawn_w = 8'd3; spawn_h = 8'd5;
        spawn_color = COL_BLUE; spawn_vx = 5'd1; spawn_vy = 5'd1;
        spawn_valid = 1'b1;
        applyTick({8'd195, 8'd100}, 1'b0, 4'd7);
        @(negedge clk);
        spawn_valid = 1'b0;
        checkOutput("refillCount", 32'(active_count), 32'd8);
        checkOutput("refillPosA", 32'(pos_a), 32'h0A0A);
        checkOutput("refillRenderA", 32'(render_a), 32'd1);
        checkOutput("refillReady", 32'(spawn_ready), 32'd0);
`endif

        // Spawn and tick together, overrun during the sweep, then reset mid-sweep.
        applyReset();
        rd_idx_a = 3'd0;
        @(negedge clk);
        spawn_x = 8'd50; spawn_y = 8'd50; spawn_w = 8'd1; spawn_h = 8'd1;
        spawn_color = COL_WHITE; spawn_vx = 5'd2; spawn_vy = 5'h1F;
        spawn_valid = 1'b1;
        run = 1'b1;
        frame_tick = 1'b1;
        checkOutput("comboReady", 32'(spawn_ready), 32'd1);
        spawnQ.push_back(0);
        e.pos = 16'h3431; e.render = 1'b1; e.count = 4'd1;
        sweepQ.push_back(e);
        @(negedge clk);
        spawn_valid = 1'b0;
        frame_tick = 1'b0;
        checkOutput("comboBusyRise", 32'(busy), 32'd1);
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            frame_tick = (cnt == 3);
            @(negedge clk);
        end
        frame_tick = 1'b0;
        checkOutput("busyCycles", 32'(cnt), 32'd8);
        checkOutput("overrunSet", 32'(tick_overrun), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("noExtraSweep", 32'(busy), 32'd0);
        checkOutput("movedOnce", 32'(pos_a), 32'h3431);

        run = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        checkOutput("runLowIgnored", 32'(busy), 32'd0);

        run = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midSweepBusy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRstBusy", 32'(busy), 32'd0);
        checkOutput("asyncRstCount", 32'(active_count), 32'd0);
        checkOutput("asyncRstOverrun", 32'(tick_overrun), 32'd0);
        checkOutput("asyncRstPosA", 32'(pos_a), 32'd0);
        checkOutput("asyncRstRenderA", 32'(render_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b0;

        // Left edge exit and independent port B.
        applyReset();
        applyStimulus(8'd1, 8'd50, 8'd5, 8'd7, COL_WHITE, 5'h1D, 5'd0, 0);
        applyStimulus(8'd30, 8'd40, 8'd9, 8'd11, COL_BLUE, 5'd0, 5'd0, 1);
        rd_idx_a = 3'd0;
        rd_idx_b = 3'd1;
        #1;
        checkOutput("portBSize", 32'(size_b), 32'h090B);
        checkOutput("portBColor", 32'(color_b), 32'(COL_BLUE));
        checkOutput("portBPos", 32'(pos_b), 32'h1E28);
        checkOutput("portASize", 32'(size_a), 32'h0507);
        checkOutput("portAColor", 32'(color_a), 32'(COL_WHITE));
`ifdef BULLET_WRAP_EN
        applyTick({8'd199, 8'd50}, 1'b1, 4'd2);
`else
        applyTick({8'd1, 8'd50}, 1'b0, 4'd1);
`endif
        checkOutput("portBAfterTick", 32'(pos_b), 32'h1E28);
        checkOutput("portBRender", 32'(render_b), 32'd1);

        repeat (2) @(negedge clk);
        checkOutput("spawnQueueDrained", 32'(spawnQ.size()), 32'd0);
        checkOutput("sweepQueueDrained", 32'(sweepQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bullet_pool.md
Name: bullet_pool

Overview:
- Parametrised bullet store and motion engine; successor to the fixed 8-entry bullet table.
- Holds NUM_BULLETS entries: position, size, colour, signed velocity, active flag.
- Accepts spawn requests through a valid/ready handshake and steps all active bullets once per frame tick.
- Two combinational read ports: port A for the VGA renderer, port B for collision/damage logic.

Parameters:
- NUM_BULLETS, 8, number of entries (power of two, 2..64)
- COORD_W, 8, width of x/y position and w/h size fields
- COLOR_W, 3, colour code width (000 white, 001 green, 010 blue)
- VEL_W, 4, signed per-axis velocity width (pixels per tick)
- X_MAX, 200, largest legal x coordinate (inclusive)
- Y_MAX, 200, largest legal y coordinate (inclusive)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  enables motion; ticks arriving while low are ignored
- frame_tick  in  1  single-cycle pulse, once per frame
- spawn_valid  in  1  spawn request
- spawn_ready  out  1  spawn slot available and engine idle
- spawn_x, spawn_y  in  COORD_W  initial position
- spawn_w, spawn_h  in  COORD_W  size
- spawn_color  in  COLOR_W  colour
- spawn_vx, spawn_vy  in  VEL_W  signed velocity
- spawn_idx  out  IDX_W  slot taken by the last accepted spawn; IDX_W = $clog2(NUM_BULLETS)
- rd_idx_a, rd_idx_b  in  IDX_W  read indices
- pos_a, size_a  out  2*COORD_W  {x,y} and {w,h}, entry rd_idx_a
- color_a  out  COLOR_W;  render_a  out  1  (same entry)
- pos_b, size_b, color_b, render_b  as port A, entry rd_idx_b
- active_count  out  IDX_W+1  number of active entries
- busy  out  1  update sweep in progress
- tick_overrun  out  1  sticky; a tick arrived while busy

Behaviour:
- Reset (async, rst_n=0): all entries zeroed and inactive; FSM in IDLE. spawn_idx, active_count, busy and tick_overrun are 0. Read ports show zeros.
- Read ports are purely combinational from the entry registers. Port B's size and colour come from rd_idx_b. Port A and port B are fully independent.
- FSM states: IDLE and SWEEP.
  - IDLE -> SWEEP: on frame_tick && run. Sweep pointer is set to 0 and busy=1 on the next cycle.
  - SWEEP: one entry per cycle, indices 0..NUM_BULLETS-1. After the last entry -> IDLE. Latency is exactly NUM_BULLETS cycles of busy.
- Per-entry step:
  - Inactive entries are untouched.
  - Active entries: nx = x + sext(vx), ny = y + sext(vy), evaluated at COORD_W+2 signed width.
  - If nx<0, nx>X_MAX, ny<0 or ny>Y_MAX: the entry is cleared inactive and its position is left unchanged.
  - Otherwise the position is updated to (nx, ny).
- Spawn handshake:
  - spawn_ready = (state==IDLE) && at least one free entry.
  - A transfer occurs when spawn_valid && spawn_ready at the clock edge. The lowest-index free entry is written with active=1, and spawn_idx takes that index.
- Simultaneous spawn and frame_tick in IDLE: the spawn completes first, and the sweep starts next cycle and includes the new entry.
- frame_tick while busy: dropped, and tick_overrun is set (cleared only by reset). frame_tick with run=0: ignored, no overrun.
- Full (active_count==NUM_BULLETS): spawn_ready=0.
- run deasserted mid-sweep: the sweep completes.
- active_count tracks spawns (+1) and deactivations (-1). A spawn and a deactivation can never occur in the same cycle.

Optional Feature:
- Macro: BULLET_WRAP_EN.
- Defined: an out-of-range axis wraps instead of deactivating.
  - Result >MAX becomes result-(MAX+1).
  - Result <0 becomes result+(MAX+1).
  - The entry stays active.
- Undefined: deactivate as above.

Decomposition:
- Package bullet_pkg:
  - bullet_t struct {active, color, w, h, x, y}.
  - Colour constants COL_WHITE, COL_GREEN, COL_BLUE.
  - FSM state enum.
- Sub-module bullet_alloc: combinational lowest-free-index priority encoder over the active vector; outputs free_idx and any_free.

Test Plan:
- Reset, then spawn (x=64,y=19,vx=0,vy=+10) -> spawn_idx=0, render_a=1 at rd_idx_a=0, active_count=1.
- Above bullet plus 19 ticks, run=1 -> y=19+190=209>200 on tick 19, so the entry deactivates and active_count=0. With BULLET_WRAP_EN: y=8 and the entry stays active.
- Fill 8 slots -> spawn_ready=0. Hold spawn_valid, then let entry 3 exit -> next spawn gets idx 3.
- Spawn and frame_tick in the same cycle -> spawn accepted, busy rises next cycle for exactly 8 cycles, and the new entry moves.
- Tick during busy -> tick_overrun=1, no extra sweep. rst_n low mid-sweep -> all outputs 0 immediately.
- vx=-3 at x=1 -> deactivated (wrap build: x=199). Port B with rd_idx_b≠rd_idx_a returns its own entry's size and colour.
